// File: rtl/csi2_video_pkg.sv
// rtl/csi2_video_pkg.sv - shared types and helpers for the CSI-2 video ROI crop stage
package csi2_video_pkg;

  localparam int ROI_COORD_WIDTH = 12;
  localparam int SOF_BIT = 0;

  typedef logic [ROI_COORD_WIDTH-1:0] coord_t;

  typedef struct packed {
    coord_t x_start;
    coord_t x_len;
    coord_t y_start;
    coord_t y_len;
    logic   enable;
  } roi_cfg_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } roi_state_t;

  // Counters park at all-ones instead of wrapping on oversized frames.
  function automatic coord_t coord_sat_inc(input coord_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/csi2_roi_coord_cnt.sv
// rtl/csi2_roi_coord_cnt.sv - pixel column/row counters and window compare for the ROI crop
module csi2_roi_coord_cnt
  import csi2_video_pkg::*;
(
  input  logic     clk_i,
  input  logic     srst_i,
  input  logic     beat_i,
  input  logic     sof_i,
  input  logic     eol_i,
  input  roi_cfg_t cfg_i,
  output logic     keep_o,
  output logic     edge_eol_o,
  output logic     short_line_o,
  output logic     x_nonzero_o
);

  coord_t x_q;
  coord_t y_q;
  coord_t x_cur;
  coord_t y_cur;
  logic [ROI_COORD_WIDTH:0] x_end;
  logic [ROI_COORD_WIDTH:0] y_end;
  logic [ROI_COORD_WIDTH:0] x_inc;
  logic x_in;
  logic y_in;

  // An SOF beat is itself pixel (0,0), so it sees zeroed coordinates.
  assign x_cur = sof_i ? '0 : x_q;
  assign y_cur = sof_i ? '0 : y_q;

  // One extra bit so start+len never overflows; x+1 == end marks the right edge.
  assign x_end = {1'b0, cfg_i.x_start} + {1'b0, cfg_i.x_len};
  assign y_end = {1'b0, cfg_i.y_start} + {1'b0, cfg_i.y_len};
  assign x_inc = {1'b0, x_cur} + 1'b1;

  assign x_in = (x_cur >= cfg_i.x_start) && ({1'b0, x_cur} < x_end);
  assign y_in = (y_cur >= cfg_i.y_start) && ({1'b0, y_cur} < y_end);

  assign keep_o       = !cfg_i.enable || (x_in && y_in);
  assign edge_eol_o   = x_in && y_in && (x_inc == x_end);
  assign short_line_o = cfg_i.enable && eol_i && y_in && (x_inc < x_end);
  assign x_nonzero_o  = (x_q != '0);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (beat_i) begin
      if (eol_i) begin
        x_q <= '0;
        y_q <= coord_sat_inc(y_cur);
      end else begin
        x_q <= coord_sat_inc(x_cur);
        y_q <= y_cur;
      end
    end
  end

endmodule

// File: rtl/csi2_video_roi_crop.sv
// rtl/csi2_video_roi_crop.sv - rectangular region-of-interest crop on a CSI-2 pixel stream
module csi2_video_roi_crop
  import csi2_video_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int TDATA_WIDTH = 16,
  parameter int COORD_WIDTH = ROI_COORD_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     enable_i,
  input  logic [COORD_WIDTH-1:0]   x_start_i,
  input  logic [COORD_WIDTH-1:0]   x_len_i,
  input  logic [COORD_WIDTH-1:0]   y_start_i,
  input  logic [COORD_WIDTH-1:0]   y_len_i,
  input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
  input  logic                     video_i_tvalid,
  output logic                     video_i_tready,
  input  logic                     video_i_tlast,
  input  logic [0:0]               video_i_tuser,
  output logic [TDATA_WIDTH-1:0]   video_o_tdata,
  output logic                     video_o_tvalid,
  input  logic                     video_o_tready,
  output logic                     video_o_tlast,
  output logic [0:0]               video_o_tuser,
  output logic [TDATA_WIDTH/8-1:0] video_o_tkeep,
  output logic [TDATA_WIDTH/8-1:0] video_o_tstrb,
  output logic [0:0]               video_o_tid,
  output logic [0:0]               video_o_tdest,
  output logic                     short_line_o,
  output logic                     frame_err_o
);

  roi_state_t state_q;
  roi_cfg_t   cfg_q;
  roi_cfg_t   cfg_live;
  roi_cfg_t   cfg_eff;
  logic       sof_pending_q;

  logic [TDATA_WIDTH-1:0] out_data_q;
  logic                   out_valid_q;
  logic                   out_user_q;
  logic                   out_last_q;

  logic in_ready;
  logic accepted;
  logic sof_in;
  logic sof_beat;
  logic beat;
  logic keep_beat;
  logic cnt_keep;
  logic cnt_edge;
  logic cnt_short;
  logic x_nonzero;
  logic user_next;
  logic last_next;
  logic [TDATA_WIDTH-1:0] data_next;

  // Input is consumed whenever the single output slot is free or draining.
  assign in_ready = !out_valid_q || video_o_tready;
  assign accepted = video_i_tvalid && in_ready;
  assign sof_in   = video_i_tuser[SOF_BIT];
  assign sof_beat = accepted && sof_in;
  assign beat     = accepted && ((state_q == ACTIVE) || sof_in);

  assign cfg_live.x_start = x_start_i;
  assign cfg_live.x_len   = x_len_i;
  assign cfg_live.y_start = y_start_i;
  assign cfg_live.y_len   = y_len_i;
  assign cfg_live.enable  = enable_i;

  // The SOF beat already belongs to the new frame, so it uses the live settings.
  assign cfg_eff = sof_in ? cfg_live : cfg_q;

  csi2_roi_coord_cnt u_coord_cnt (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .beat_i       (beat),
    .sof_i        (sof_in),
    .eol_i        (video_i_tlast),
    .cfg_i        (cfg_eff),
    .keep_o       (cnt_keep),
    .edge_eol_o   (cnt_edge),
    .short_line_o (cnt_short),
    .x_nonzero_o  (x_nonzero)
  );

  assign keep_beat = beat && cnt_keep;
  assign user_next = cfg_eff.enable ? (sof_pending_q || sof_in) : sof_in;
  assign last_next = cfg_eff.enable ? (cnt_edge || video_i_tlast) : video_i_tlast;
  assign data_next = {video_i_tdata[TDATA_WIDTH-1:PX_WIDTH], video_i_tdata[PX_WIDTH-1:0]};

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q       <= WAIT_SOF;
      cfg_q         <= '0;
      sof_pending_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_user_q    <= 1'b0;
      out_last_q    <= 1'b0;
      short_line_o  <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      short_line_o <= beat && cnt_short;
      frame_err_o  <= sof_beat && (state_q == ACTIVE) && x_nonzero;
      if (sof_beat) begin
        state_q <= ACTIVE;
        cfg_q   <= cfg_live;
      end
      if (keep_beat) begin
        sof_pending_q <= 1'b0;
      end else if (sof_beat) begin
        sof_pending_q <= 1'b1;
      end
      if (in_ready) begin
        out_valid_q <= keep_beat;
        if (keep_beat) begin
          out_data_q <= data_next;
          out_user_q <= user_next;
          out_last_q <= last_next;
        end
      end
    end
  end

  assign video_i_tready   = in_ready;
  assign video_o_tdata    = out_data_q;
  assign video_o_tvalid   = out_valid_q;
  assign video_o_tuser[0] = out_user_q;
  assign video_o_tlast    = out_last_q;
  assign video_o_tkeep    = '1;
  assign video_o_tstrb    = '1;
  assign video_o_tid      = '0;
  assign video_o_tdest    = '0;

endmodule

// File: tb/tb_csi2_video_roi_crop.sv
// tb/tb_csi2_video_roi_crop.sv - randomized self-checking bench for csi2_video_roi_crop
module tb_csi2_video_roi_crop;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic        enable_i;
  logic [11:0] x_start_i, x_len_i, y_start_i, y_len_i;
  logic [15:0] in_tdata;
  logic        in_tvalid, in_tready, in_tlast;
  logic [0:0]  in_tuser;
  logic [15:0] out_tdata;
  logic        out_tvalid, out_tready, out_tlast;
  logic [0:0]  out_tuser, out_tid, out_tdest;
  logic [1:0]  out_tkeep, out_tstrb;
  logic        short_line_o, frame_err_o;

  csi2_video_roi_crop dut (
    .clk_i(clk_i), .srst_i(srst_i), .enable_i(enable_i),
    .x_start_i(x_start_i), .x_len_i(x_len_i), .y_start_i(y_start_i), .y_len_i(y_len_i),
    .video_i_tdata(in_tdata), .video_i_tvalid(in_tvalid), .video_i_tready(in_tready),
    .video_i_tlast(in_tlast), .video_i_tuser(in_tuser),
    .video_o_tdata(out_tdata), .video_o_tvalid(out_tvalid), .video_o_tready(out_tready),
    .video_o_tlast(out_tlast), .video_o_tuser(out_tuser), .video_o_tkeep(out_tkeep),
    .video_o_tstrb(out_tstrb), .video_o_tid(out_tid), .video_o_tdest(out_tdest),
    .short_line_o(short_line_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: frame walk in plain integers, expected output beats queued in order.
  typedef struct packed { logic [15:0] d; logic u; logic l; } beat_t;
  beat_t exp_q[$];
  bit m_started, m_en, m_pend;
  int mx, my, m_xs, m_xl, m_ys, m_yl;
  bit p_keep, p_short, p_ferr;

  function automatic void model_reset();
    m_started = 0; m_pend = 0; mx = 0; my = 0;
    m_en = 0; m_xs = 0; m_xl = 0; m_ys = 0; m_yl = 0;
  endfunction

  function automatic void model_beat(logic [15:0] d, bit sof, bit eol);
    bit rows_in;
    beat_t b;
    p_keep = 0; p_short = 0; p_ferr = 0;
    if (!m_started && !sof) return;
    p_ferr = sof && m_started && (mx != 0);
    if (sof) begin
      m_started = 1; mx = 0; my = 0; m_pend = 1;
      m_en = enable_i; m_xs = x_start_i; m_xl = x_len_i; m_ys = y_start_i; m_yl = y_len_i;
    end
    rows_in = (my >= m_ys) && (my < m_ys + m_yl);
    p_keep  = !m_en || (rows_in && mx >= m_xs && mx < m_xs + m_xl);
    p_short = m_en && eol && rows_in && (mx < m_xs + m_xl - 1);
    if (p_keep) begin
      b.d = d;
      b.u = m_en ? m_pend : sof;
      b.l = m_en ? (eol || mx == m_xs + m_xl - 1) : eol;
      exp_q.push_back(b);
      m_pend = 0;
    end
    if (eol) begin
      mx = 0;
      my = (my < 4095) ? my + 1 : 4095;
    end else begin
      mx = (mx < 4095) ? mx + 1 : 4095;
    end
  endfunction

  int out_cnt, tuser_cnt, tlast_cnt, short_cnt, ferr_cnt;
  logic [15:0] first_data;
  bit prev_acc = 0;
  bit hold_valid = 0;
  beat_t held;

  always @(negedge clk_i) begin
    beat_t e;
    if (srst_i) begin
      exp_q.delete();
      model_reset();
      prev_acc = 0;
      hold_valid = 0;
    end else begin
      chk("short_line_o", short_line_o, prev_acc ? p_short : 1'b0);
      chk("frame_err_o", frame_err_o, prev_acc ? p_ferr : 1'b0);
      if (short_line_o) short_cnt++;
      if (frame_err_o) ferr_cnt++;
      if (prev_acc && p_keep) chk("latency_tvalid", out_tvalid, 1);
      if (hold_valid) begin
        chk("stall_tvalid", out_tvalid, 1);
        chk("stall_beat", {out_tdata, out_tuser[0], out_tlast}, held);
      end
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_tdata, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("out_tdata", out_tdata, e.d);
          chk("out_tuser", out_tuser[0], e.u);
          chk("out_tlast", out_tlast, e.l);
        end
        out_cnt++;
        if (out_cnt == 1) first_data = out_tdata;
        if (out_tuser[0]) tuser_cnt++;
        if (out_tlast) tlast_cnt++;
      end
      hold_valid = out_tvalid && !out_tready;
      held = {out_tdata, out_tuser[0], out_tlast};
      prev_acc = in_tvalid && in_tready;
      if (prev_acc) model_beat(in_tdata, in_tuser[0], in_tlast);
    end
  end

  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit gap_en = 0;

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      out_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    end
  end

  task automatic send_beat(input logic [15:0] d, input bit sof, input bit eol);
    int g = 0;
    bit acc;
    if (gap_en) while ($urandom_range(1) == 0) begin @(posedge clk_i); #1; end
    in_tdata = d; in_tuser[0] = sof; in_tlast = eol; in_tvalid = 1'b1;
    do begin
      @(negedge clk_i); acc = in_tready;
      @(posedge clk_i); #1; g++;
    end while (!acc && g < 1000);
    if (!acc) chk("send_timeout", g, 0);
    in_tvalid = 1'b0;
  endtask

  task automatic set_cfg(input bit en, input int xs, input int xl, input int ys, input int yl);
    enable_i = en; x_start_i = 12'(xs); x_len_i = 12'(xl); y_start_i = 12'(ys); y_len_i = 12'(yl);
  endtask

  task automatic send_frame(input int w, input int h, input bit rnd, input bit scramble, input int stop_beats);
    int n = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (stop_beats > 0 && n == stop_beats) return;
        send_beat(rnd ? 16'($urandom) : {8'(y), 8'(x)}, x == 0 && y == 0, x == w - 1);
        n++;
        if (scramble && n == 1)
          set_cfg($urandom_range(1), $urandom_range(9), $urandom_range(9), $urandom_range(5), $urandom_range(5));
      end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_tvalid) && g < 2000) begin @(posedge clk_i); #1; g++; end
    chk("drain_done", exp_q.size(), 0);
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic clear_cnt();
    out_cnt = 0; tuser_cnt = 0; tlast_cnt = 0; short_cnt = 0; ferr_cnt = 0; first_data = 16'hFFFF;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    srst_i = 1'b1; in_tvalid = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    srst_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    srst_i = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tuser = '0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    clear_cnt();
    repeat (3) @(posedge clk_i); #1;
    srst_i = 1'b0;

    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tdata", out_tdata, 0);
    chk("rst_tuser", out_tuser, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_short", short_line_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_tkeep_tstrb", {out_tkeep, out_tstrb}, 4'hF);
    chk("rst_tid_tdest", {out_tid, out_tdest}, 0);
    chk("rst_in_tready", in_tready, 1);

    // 1: basic window
    clear_cnt(); set_cfg(1, 2, 3, 1, 2);
    send_frame(8, 4, 0, 0, 0); drain();
    chk("t1_out_cnt", out_cnt, 6);
    chk("t1_first_data", first_data, 16'h0102);
    chk("t1_tuser_cnt", tuser_cnt, 1);
    chk("t1_tlast_cnt", tlast_cnt, 2);
    chk("t1_pulses", short_cnt + ferr_cnt, 0);

    // 2: bypass
    clear_cnt(); set_cfg(0, 2, 3, 1, 2);
    send_frame(8, 4, 0, 0, 0); drain();
    chk("t2_out_cnt", out_cnt, 32);
    chk("t2_first_data", first_data, 16'h0000);
    chk("t2_tuser_cnt", tuser_cnt, 1);
    chk("t2_tlast_cnt", tlast_cnt, 4);

    // 3: window runs past the line end
    clear_cnt(); set_cfg(1, 6, 4, 1, 2);
    send_frame(8, 4, 0, 0, 0); drain();
    chk("t3_out_cnt", out_cnt, 4);
    chk("t3_tlast_cnt", tlast_cnt, 2);
    chk("t3_short_cnt", short_cnt, 2);
    chk("t3_first_data", first_data, 16'h0106);

    // 4: random backpressure, gaps and settings changed mid-frame
    rdy_mode = 1; gap_en = 1;
    for (int f = 0; f < 3; f++) begin
      int w = $urandom_range(3, 10);
      int h = $urandom_range(2, 5);
      set_cfg($urandom_range(3) != 0, $urandom_range(w), $urandom_range(1, w), $urandom_range(h - 1), $urandom_range(1, h));
      send_frame(w, h, 1, 1, 0);
    end
    drain();
    rdy_mode = 0; gap_en = 0;

    // 5: pre-SOF beats, then SOF in the middle of a line
    do_reset();
    clear_cnt(); set_cfg(1, 0, 2, 0, 8);
    for (int i = 0; i < 5; i++) send_beat(16'hA000 + 16'(i), 0, i == 4);
    send_frame(8, 4, 0, 0, 21);
    set_cfg(1, 3, 2, 1, 1);
    send_frame(8, 4, 0, 0, 0); drain();
    chk("t5_ferr_cnt", ferr_cnt, 1);
    chk("t5_out_cnt", out_cnt, 8);
    chk("t5_first_data", first_data, 16'h0000);

    // 6: empty window, then reset while the output is stalled
    clear_cnt(); set_cfg(1, 2, 0, 0, 4);
    send_frame(8, 4, 0, 0, 0); drain();
    chk("t6_zero_out", out_cnt, 0);
    set_cfg(1, 0, 4, 0, 4);
    rdy_mode = 2;
    send_beat(16'h5555, 1, 0);
    repeat (3) @(posedge clk_i); #1;
    chk("t6_stalled_valid", out_tvalid, 1);
    do_reset();
    chk("t6_post_rst_valid", out_tvalid, 0);
    rdy_mode = 0;
    clear_cnt();
    for (int i = 0; i < 3; i++) send_beat(16'hB000 + 16'(i), 0, 0);
    repeat (2) @(posedge clk_i); #1;
    chk("t6_pre_sof_out", out_cnt, 0);
    send_frame(8, 4, 0, 0, 0); drain();
    chk("t6_after_sof_out", out_cnt, 16);
    chk("t6_tlast_cnt", tlast_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
